// File: rtl/timer_bank_if.sv
// Bus bundle between the controller and the timer bank: load/mode/run/prescale
// controls toward the bank, per-channel status back toward the controller.
interface timer_bank_if #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) ();
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] set;
  logic [NCH-1:0]       periodic;
  logic [NCH-1:0]       run;
  logic [PRESC_W-1:0]   prescale;
  logic [NCH-1:0]       irq_clr;
  logic [NCH-1:0]       irq;
  logic [NCH-1:0]       expired;
  logic [NCH-1:0]       busy;
  logic [NCH*WIDTH-1:0] cnt_out;

  modport master (
    output load, set, periodic, run, prescale, irq_clr,
    input  irq, expired, busy, cnt_out
  );

  modport slave (
    input  load, set, periodic, run, prescale, irq_clr,
    output irq, expired, busy, cnt_out
  );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counting interval timer bank with a shared prescaler,
// per-channel one-shot/periodic mode, pause, and sticky expiry interrupts.
module timer_bank #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  timer_bank_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_s;
  state_e             state_q  [NCH];
  state_e             state_d  [NCH];
  logic [WIDTH-1:0]   cnt_q    [NCH];
  logic [WIDTH-1:0]   cnt_d    [NCH];
  logic [WIDTH-1:0]   reload_q [NCH];
  logic [WIDTH-1:0]   reload_d [NCH];
  logic [NCH-1:0]     mode_q, mode_d;
  logic [NCH-1:0]     irq_q, irq_d;
  logic [NCH-1:0]     expired_q, expired_d;

  // State register: sync reset abandons any count in flight with no expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= {PRESC_W{1'b0}};
      mode_q    <= {NCH{1'b0}};
      irq_q     <= {NCH{1'b0}};
      expired_q <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= {WIDTH{1'b0}};
        reload_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      expired_q <= expired_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  // Next-state logic: shared prescaler plus per-channel IDLE/COUNT machines.
  always_comb begin
    tick_s    = (presc_q >= bus.prescale);
    presc_d   = presc_q;
    mode_d    = mode_q;
    irq_d     = irq_q;
    expired_d = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];
    end

    if (tick_s) begin
      presc_d = {PRESC_W{1'b0}};
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    for (int i = 0; i < NCH; i++) begin
      // Clear is applied first so that a same-cycle expiry overrides it.
      if (bus.irq_clr[i]) begin
        irq_d[i] = 1'b0;
      end else begin
        irq_d[i] = irq_q[i];
      end

      if (bus.load[i]) begin
        cnt_d[i]    = bus.set[i*WIDTH +: WIDTH];
        reload_d[i] = bus.set[i*WIDTH +: WIDTH];
        mode_d[i]   = bus.periodic[i];
        state_d[i]  = S_COUNT;
      end else begin
        case (state_q[i])
          S_COUNT: begin
            if (tick_s && bus.run[i]) begin
              if (cnt_q[i] != {WIDTH{1'b0}}) begin
                cnt_d[i] = cnt_q[i] - WIDTH'(1);
              end else begin
                expired_d[i] = 1'b1;
                irq_d[i]     = 1'b1;
                if (mode_q[i]) begin
                  cnt_d[i] = reload_q[i];
                end else begin
                  state_d[i] = S_IDLE;
                end
              end
            end else begin
              cnt_d[i] = cnt_q[i];
            end
          end
          S_IDLE: begin
            state_d[i] = S_IDLE;
          end
          default: begin
            state_d[i] = S_IDLE;
          end
        endcase
      end
    end
  end

  // Output logic: every output is a direct view of a register.
  always_comb begin
    bus.irq     = irq_q;
    bus.expired = expired_q;
    bus.busy    = {NCH{1'b0}};
    bus.cnt_out = {NCH*WIDTH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      bus.busy[i]                   = (state_q[i] == S_COUNT);
      bus.cnt_out[i*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: hand-computed vectors checked with immediate
// assertions one clock edge at a time.
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int PW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  timer_bank_if #(.NCH(NCH), .WIDTH(W), .PRESC_W(PW)) bus ();

  timer_bank #(.NCH(NCH), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return bus.cnt_out[ch*W +: W];
  endfunction

  task automatic set_val(input int ch, input logic [W-1:0] v);
    bus.set[ch*W +: W] = v;
  endtask

  initial begin
    bus.load     = 4'h0;
    bus.set      = 32'h0;
    bus.periodic = 4'h0;
    bus.run      = 4'hF;
    bus.prescale = 4'h0;
    bus.irq_clr  = 4'h0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_irq", bus.irq, 4'h0);
    chk("rst_expired", bus.expired, 4'h0);
    chk("rst_busy", bus.busy, 4'h0);
    chk("rst_cnt", bus.cnt_out, 32'h0);
    rst = 1'b0;

    // One-shot ch0 set=3, prescale=0
    bus.load[0] = 1'b1;
    set_val(0, 8'd3);
    bus.periodic[0] = 1'b0;
    step();
    bus.load[0] = 1'b0;
    chk("os_load_cnt", cnt(0), 8'd3);
    chk("os_load_busy", bus.busy[0], 1'b1);
    step(); chk("os_cnt2", cnt(0), 8'd2);
    step(); chk("os_cnt1", cnt(0), 8'd1);
    step(); chk("os_cnt0", cnt(0), 8'd0);
    chk("os_noexp_yet", bus.expired[0], 1'b0);
    step();
    chk("os_expired", bus.expired[0], 1'b1);
    chk("os_irq", bus.irq[0], 1'b1);
    chk("os_busy_off", bus.busy[0], 1'b0);
    chk("os_cnt_hold", cnt(0), 8'd0);
    step();
    chk("os_exp_pulse_end", bus.expired[0], 1'b0);
    chk("os_irq_sticky", bus.irq[0], 1'b1);
    chk("os_cnt_stays0", cnt(0), 8'd0);

    // irq_clr alone
    bus.irq_clr[0] = 1'b1;
    step();
    bus.irq_clr[0] = 1'b0;
    chk("clr_alone_irq", bus.irq[0], 1'b0);

    // Periodic ch1 set=2: expiry every 3 clocks
    bus.load[1] = 1'b1;
    set_val(1, 8'd2);
    bus.periodic[1] = 1'b1;
    step();
    bus.load[1] = 1'b0;
    chk("per_load_cnt", cnt(1), 8'd2);
    for (int p = 0; p < 5; p++) begin
      step();
      chk("per_cnt1", cnt(1), 8'd1);
      chk("per_noexp_a", bus.expired[1], 1'b0);
      step();
      chk("per_cnt0", cnt(1), 8'd0);
      chk("per_noexp_b", bus.expired[1], 1'b0);
      step();
      chk("per_reload", cnt(1), 8'd2);
      chk("per_expired", bus.expired[1], 1'b1);
      chk("per_busy", bus.busy[1], 1'b1);
      chk("per_irq", bus.irq[1], 1'b1);
    end

    // Prescale=3, ch2 set=1 loaded on first edge after reset
    bus.prescale = 4'd3;
    rst = 1'b1;
    step();
    chk("rst2_busy", bus.busy, 4'h0);
    chk("rst2_irq", bus.irq, 4'h0);
    rst = 1'b0;
    bus.load[2] = 1'b1;
    set_val(2, 8'd1);
    bus.periodic[2] = 1'b0;
    step();
    bus.load[2] = 1'b0;
    chk("ps_load_cnt", cnt(2), 8'd1);
    step(); chk("ps_e2", cnt(2), 8'd1);
    step(); chk("ps_e3", cnt(2), 8'd1);
    step(); chk("ps_tick1", cnt(2), 8'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ps_wait_exp", bus.expired[2], 1'b0);
      chk("ps_wait_busy", bus.busy[2], 1'b1);
    end
    step();
    chk("ps_expired", bus.expired[2], 1'b1);
    chk("ps_busy_off", bus.busy[2], 1'b0);
    chk("ps_irq", bus.irq[2], 1'b1);
    step();
    chk("ps_exp_end", bus.expired[2], 1'b0);

    // Pause: ch0 set=5, run low for 10 clocks at cnt=3
    bus.prescale = 4'd0;
    bus.load[0] = 1'b1;
    set_val(0, 8'd5);
    step();
    bus.load[0] = 1'b0;
    chk("pz_load", cnt(0), 8'd5);
    step(); chk("pz_cnt4", cnt(0), 8'd4);
    step(); chk("pz_cnt3", cnt(0), 8'd3);
    bus.run[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pz_frozen", cnt(0), 8'd3);
      chk("pz_noexp", bus.expired[0], 1'b0);
    end
    bus.run[0] = 1'b1;
    step(); chk("pz_cnt2", cnt(0), 8'd2);
    step(); chk("pz_cnt1", cnt(0), 8'd1);
    step(); chk("pz_cnt0", cnt(0), 8'd0);
    chk("pz_noexp_late", bus.expired[0], 1'b0);
    step();
    chk("pz_expired", bus.expired[0], 1'b1);
    chk("pz_irq", bus.irq[0], 1'b1);

    // Load coinciding with expiry on ch3
    bus.load[3] = 1'b1;
    set_val(3, 8'd0);
    bus.periodic[3] = 1'b0;
    step();
    chk("le_load0", cnt(3), 8'd0);
    set_val(3, 8'd4);
    step();
    bus.load[3] = 1'b0;
    chk("le_noexp", bus.expired[3], 1'b0);
    chk("le_noirq", bus.irq[3], 1'b0);
    chk("le_reloaded", cnt(3), 8'd4);
    step(); chk("le_cnt3", cnt(3), 8'd3);
    step(); chk("le_cnt2", cnt(3), 8'd2);
    step(); chk("le_cnt1", cnt(3), 8'd1);
    step(); chk("le_cnt0", cnt(3), 8'd0);

    // irq_clr on the expiry edge: set wins
    bus.irq_clr[3] = 1'b1;
    step();
    chk("ce_expired", bus.expired[3], 1'b1);
    chk("ce_irq_kept", bus.irq[3], 1'b1);
    step();
    bus.irq_clr[3] = 1'b0;
    chk("ce_irq_cleared", bus.irq[3], 1'b0);
    chk("ce_exp_end", bus.expired[3], 1'b0);

    // All channels counting, then reset mid-count
    bus.periodic = 4'hF;
    set_val(0, 8'd10);
    set_val(1, 8'd20);
    set_val(2, 8'd30);
    set_val(3, 8'd40);
    bus.load = 4'hF;
    step();
    bus.load = 4'h0;
    step();
    step();
    step();
    chk("all_cnt", bus.cnt_out, 32'h251B1107);
    chk("all_busy", bus.busy, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", bus.cnt_out, 32'h0);
    chk("mid_rst_busy", bus.busy, 4'h0);
    chk("mid_rst_irq", bus.irq, 4'h0);
    chk("mid_rst_exp", bus.expired, 4'h0);
    for (int k = 0; k < 50; k++) begin
      step();
      chk("post_rst_exp", bus.expired, 4'h0);
      chk("post_rst_busy", bus.busy, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel down-counting interval timer bank; successor to the single-channel 8-bit one-shot timer.
- Generalised in width and channel count, with a shared prescaler, per-channel one-shot/periodic mode, pause, and sticky interrupts with clear.
- Sits beside the controller FSM; the controller loads durations and polls or takes `irq`.

Parameters:
- NCH, 4, number of independent timer channels (1..16)
- WIDTH, 8, counter width per channel in bits (2..32)
- PRESC_W, 4, prescaler compare width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  NCH  per-channel load strobe
- set  in  NCH*WIDTH  load values; channel i at [i*WIDTH +: WIDTH]
- periodic  in  NCH  mode captured at load; 1 = auto-reload, 0 = one-shot
- run  in  NCH  per-channel count enable; 0 = pause (count frozen)
- prescale  in  PRESC_W  a tick occurs every prescale+1 clocks
- irq_clr  in  NCH  per-channel sticky-irq clear
- irq  out  NCH  sticky expiry flag per channel
- expired  out  NCH  one-cycle registered expiry pulse per channel
- busy  out  NCH  channel in COUNT state
- cnt_out  out  NCH*WIDTH  current count per channel

Behaviour:
- Reset (rst=1 at an edge):
  - presc_cnt=0.
  - All channels: state IDLE, cnt=0, reload=0, mode=0.
  - irq=0, expired=0, busy=0, cnt_out=0.
  - rst overrides every other input; reset mid-count abandons the count with no expiry.
- Prescaler:
  - Internal presc_cnt, PRESC_W bits.
  - tick = (presc_cnt >= prescale), combinational.
  - On tick, presc_cnt <= 0; else presc_cnt <= presc_cnt + 1.
  - The prescaler free-runs regardless of load/run.
  - prescale=0 gives a tick every cycle.
  - Lowering prescale below presc_cnt produces a tick on the next edge (>= compare).
- Per-channel FSM, states IDLE and COUNT, priority highest first:
  1. load=1: cnt <= set_i, reload <= set_i, mode <= periodic_i, state <= COUNT. Allowed in either state (restart). Suppresses any expiry that same cycle.
  2. COUNT & tick & run & cnt!=0: cnt <= cnt-1.
  3. COUNT & tick & run & cnt==0 (expiry): expired_i <= 1 for exactly one cycle; irq_i <= 1.
     - If mode=1: cnt <= reload, stay in COUNT.
     - If mode=0: state <= IDLE, cnt holds 0.
  4. Otherwise: hold.
     - run=0 freezes cnt.
     - IDLE ignores tick.
- Timing: a load of value N gives expiry after N+1 ticks. Periodic period = (N+1)*(prescale+1) clocks.
- set=0 is legal: expiry on the first tick after load. Periodic set=0 expires on every tick.
- irq:
  - Sticky; cleared by irq_clr_i=1 at an edge.
  - Expiry and irq_clr in the same cycle: set wins, irq stays 1.
  - Load does not clear irq.
- expired is registered (high in the cycle after the expiring edge) and is independent of irq_clr.
- busy = (state==COUNT). cnt_out mirrors the internal cnt registers.
- Arithmetic is unsigned WIDTH-bit. cnt never decrements below 0; there is no wrap-around.
- Channels are fully independent except for the shared tick.

Test Plan:
- Reset, then prescale=0, one load pulse ch0 set=3 periodic=0 -> cnt_out0 3,2,1,0; expired0 high one cycle 4 edges after the load edge; irq0=1, busy0=0, cnt_out0 stays 0.
- prescale=0, ch1 set=2 periodic=1, run held 1 -> expired1 pulses every 3 clocks for 5 periods; cnt_out1 cycles 2,1,0; busy1 stays 1.
- After reset, prescale=3, load ch2 set=1 on the first edge -> ticks at edges 3 and 7 after load; expired2 high after edge 7 only.
- ch0 set=5, deassert run for 10 clocks mid-count at cnt=3 -> cnt_out0 holds 3 throughout; expiry delayed by exactly 10 clocks.
- Simultaneous events:
  - load and expiry same cycle -> no expired pulse; cnt reloaded.
  - irq_clr and expiry same cycle -> irq stays 1.
  - irq_clr alone -> irq 0 next cycle.
- All NCH channels loaded with different values, then rst asserted mid-count -> all outputs 0 next cycle; no expired pulses afterward.
